// File: rtl/dti_decouple_pkg.sv
// dti_pkg: shared types and elaboration helpers for the dti_decouple FIFO.
package dti_pkg;
  typedef enum logic {DTI_BP, DTI_DROP} dti_mode_e;
  localparam int SAT_W = 64;
  function automatic int clog2p1(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic dti_mode_e mode_of(input bit bp);
    return bp ? DTI_BP : DTI_DROP;
  endfunction
  function automatic logic [SAT_W-1:0] sat_max(input int w);
    return (SAT_W'(1) << w) - SAT_W'(1);
  endfunction
endpackage

// File: rtl/dti_decouple_if.sv
// dti: valid/ready data channel with producer and consumer views.
interface dti #(parameter int W_DATA = 64);
  logic [W_DATA-1:0] data;
  logic              valid;
  logic              ready;
  modport producer (output data, valid, input ready);
  modport consumer (input data, valid, output ready);
endinterface

// File: rtl/dti_decouple_ptr.sv
// dti_fifo_ptr: FIFO pointer with wrap bit, increment enable and async reset.
module dti_fifo_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);
  logic [PW-1:0] ptr_q, ptr_d;
  always_comb ptr_d = inc_i ? ptr_q + PW'(1) : ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
  assign ptr_o = ptr_q;
endmodule

// File: rtl/dti_decouple.sv
// dti_decouple: DEPTH-entry decoupling FIFO between a dti producer and consumer.
// Define DTI_DECOUPLE_LEVEL_EN to drive level with the current occupancy.
module dti_decouple
  import dti_pkg::*;
#(
  parameter int W_DATA           = 64,
  parameter int DEPTH            = 4,
  parameter int DIN_BACKPRESSURE = 1,
  parameter int W_DROP           = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  dti.consumer                      din,
  dti.producer                      dout,
  output logic [W_DROP-1:0]         drop_cnt,
  output logic [clog2p1(DEPTH)-1:0] level
);
  localparam int PW = clog2p1(DEPTH);
  localparam int AW = PW - 1;
  localparam dti_mode_e MODE = mode_of(DIN_BACKPRESSURE != 0);
  localparam logic [W_DROP-1:0] DROP_MAX = W_DROP'(sat_max(W_DROP));
  typedef logic [PW-1:0] ptr_t;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("dti_decouple: DEPTH must be a power of two >= 2");
  end
  ptr_t              wptr, rptr;
  logic [W_DATA-1:0] mem_q [DEPTH];
  logic              empty, full, push, pop, drop;
  logic [W_DROP-1:0] drop_q, drop_d;
  // Flags come only from registered pointers, so ready never passes through.
  always_comb begin
    empty      = wptr == rptr;
    full       = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    din.ready  = !rst && (MODE == DTI_DROP || !full);
    dout.valid = !empty;
    dout.data  = empty ? '0 : mem_q[rptr[AW-1:0]];
    push       = din.valid && din.ready && !full;
    pop        = dout.valid && dout.ready;
    drop       = MODE == DTI_DROP && din.valid && din.ready && full;
    drop_d     = (drop && drop_q != DROP_MAX) ? drop_q + W_DROP'(1) : drop_q;
  end
  dti_fifo_ptr #(.PW(PW)) u_wptr (.clk(clk), .rst(rst), .inc_i(push), .ptr_o(wptr));
  dti_fifo_ptr #(.PW(PW)) u_rptr (.clk(clk), .rst(rst), .inc_i(pop), .ptr_o(rptr));
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr[AW-1:0]] <= din.data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign drop_cnt = drop_q;
`ifdef DTI_DECOUPLE_LEVEL_EN
  assign level = wptr - rptr;
`else
  assign level = '0;
`endif
  a_dout_stable: assert property (@(posedge clk) disable iff (rst)
    dout.valid && !dout.ready |=> dout.valid && $stable(dout.data));
endmodule

// File: tb/tb_dti_decouple.sv
// tb_dti_decouple: scoreboard bench for backpressured and drop-mode dti_decouple.
module tb_dti_decouple;
  localparam int W = 16;
  localparam int DEPTH = 4;
`ifdef DTI_DECOUPLE_LEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  dti #(.W_DATA(W)) bi(), bo(), dri(), dro(), sai(), sao();
  logic [15:0] bp_drop, dr_drop;
  logic [1:0]  sat_drop;
  logic [2:0]  bp_lvl, dr_lvl, sat_lvl;
  dti_decouple #(.W_DATA(W), .DEPTH(DEPTH), .DIN_BACKPRESSURE(1), .W_DROP(16)) u_bp (
    .clk(clk), .rst(rst), .din(bi), .dout(bo), .drop_cnt(bp_drop), .level(bp_lvl));
  dti_decouple #(.W_DATA(W), .DEPTH(DEPTH), .DIN_BACKPRESSURE(0), .W_DROP(16)) u_dr (
    .clk(clk), .rst(rst), .din(dri), .dout(dro), .drop_cnt(dr_drop), .level(dr_lvl));
  dti_decouple #(.W_DATA(W), .DEPTH(DEPTH), .DIN_BACKPRESSURE(0), .W_DROP(2)) u_sat (
    .clk(clk), .rst(rst), .din(sai), .dout(sao), .drop_cnt(sat_drop), .level(sat_lvl));
  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] sd[$];
  int de = 0;
  int ds = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] lvl(input int n);
    return LVL_EN ? 32'(n) : 32'd0;
  endfunction
  task automatic cyc_bp(input logic v, input logic [W-1:0] d, input logic r);
    logic full;
    bi.valid = v;
    bi.data  = d;
    bo.ready = r;
    full = sb.size() == DEPTH;
    @(negedge clk);
    chk("bp_ready", 32'(bi.ready), 32'(!full));
    chk("bp_valid", 32'(bo.valid), 32'(sb.size() != 0));
    if (sb.size() != 0) chk("bp_data", 32'(bo.data), 32'(sb[0]));
    chk("bp_level", 32'(bp_lvl), lvl(sb.size()));
    @(posedge clk);
    #1;
    if (r && sb.size() != 0) void'(sb.pop_front());
    if (v && !full) sb.push_back(d);
  endtask
  task automatic cyc_dr(input logic v, input logic [W-1:0] d, input logic r);
    logic full;
    dri.valid = v;
    sai.valid = v;
    dri.data  = d;
    sai.data  = d;
    dro.ready = r;
    sao.ready = r;
    full = sd.size() == DEPTH;
    @(negedge clk);
    chk("dr_ready", 32'(dri.ready), 32'd1);
    chk("sat_ready", 32'(sai.ready), 32'd1);
    chk("dr_valid", 32'(dro.valid), 32'(sd.size() != 0));
    if (sd.size() != 0) begin
      chk("dr_data", 32'(dro.data), 32'(sd[0]));
      chk("sat_data", 32'(sao.data), 32'(sd[0]));
    end
    chk("dr_cnt", 32'(dr_drop), 32'(de));
    chk("sat_cnt", 32'(sat_drop), 32'(ds));
    chk("dr_level", 32'(dr_lvl), lvl(sd.size()));
    @(posedge clk);
    #1;
    if (v && full) begin
      de++;
      if (ds < 3) ds++;
    end
    if (r && sd.size() != 0) void'(sd.pop_front());
    if (v && !full) sd.push_back(d);
  endtask
  initial begin
    bi.valid = 0; bi.data = '0; bo.ready = 0;
    dri.valid = 0; dri.data = '0; dro.ready = 0;
    sai.valid = 0; sai.data = '0; sao.ready = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_bp_ready", 32'(bi.ready), 32'd0);
    chk("rst_dr_ready", 32'(dri.ready), 32'd0);
    chk("rst_bp_valid", 32'(bo.valid), 32'd0);
    chk("rst_bp_data", 32'(bo.data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc_bp(0, '0, 0);
    cyc_bp(0, '0, 0);
    chk("bp_drop_zero", 32'(bp_drop), 32'd0);
    for (int i = 1; i <= 4; i++) cyc_bp(1, W'(i * 16'h11), 0);
    cyc_bp(0, '0, 0);
    cyc_bp(1, 16'h55, 1);
    cyc_bp(0, '0, 0);
    for (int i = 0; i < 3; i++) cyc_bp(0, '0, 1);
    cyc_bp(0, '0, 0);
    for (int i = 0; i < 100; i++) cyc_bp(1, W'(16'h100 + i), 1);
    cyc_bp(0, '0, 1);
    cyc_bp(0, '0, 0);
    for (int i = 0; i < 3; i++) cyc_bp(1, W'(16'h70 + i), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bo.valid), 32'd0);
    chk("async_rst_ready", 32'(bi.ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc_bp(0, '0, 0);
    cyc_bp(1, 16'hAB, 0);
    cyc_bp(0, '0, 1);
    cyc_bp(0, '0, 0);
    for (int i = 0; i < 10; i++) cyc_dr(1, W'(16'h200 + i), 0);
    cyc_dr(0, '0, 0);
    chk("dr_cnt_after10", 32'(dr_drop), 32'd6);
    for (int i = 0; i < 10; i++) cyc_dr(1, W'(16'h300 + i), 0);
    cyc_dr(1, 16'h400, 1);
    for (int i = 0; i < 4; i++) cyc_dr(0, '0, 1);
    cyc_dr(0, '0, 0);
    chk("sat_cnt_final", 32'(sat_drop), 32'd3);
    chk("bp_drop_final", 32'(bp_drop), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
